// File: rtl/multicycle_data_memory_pkg.sv
// multicycle_data_memory_pkg: shared FSM state and request op encodings
// for the multicycle data memory responder.
package multicycle_data_memory_pkg;
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;
endpackage

// File: rtl/multicycle_data_memory_mem_word_array.sv
// mem_word_array: single-port word storage, synchronous write, registered read.
// Ports:
//   i_clk    clock
//   i_en     access enable for this cycle
//   i_we     1 = write i_wdata at i_index, 0 = read i_index into o_rdata
//   i_index  word index
//   i_wdata  write data
//   o_rdata  read data, updated the cycle after a read access
module mem_word_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16384,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_index,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en && i_we) r_mem[i_index] <= i_wdata;
        if (i_en && !i_we) r_rdata <= r_mem[i_index];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/multicycle_data_memory.sv
// multicycle_data_memory: fixed-latency responder for the multicycle CPU
// memory interface; one request in flight, response after LATENCY wait cycles.
// Ports:
//   i_clk              clock
//   i_reset            synchronous active-high reset
//   i_is_input_valid   request present
//   i_mem_read         request is a read
//   i_mem_write        request is a write
//   i_addr             byte address (word index = addr >> 2, wrapped to depth)
//   i_din              write data
//   o_is_ready         can accept a request (IDLE)
//   o_is_output_valid  one-cycle response strobe
//   o_dout             read data during a read response, else 0
//   o_req_error        one-cycle pulse for a rejected illegal request
module multicycle_data_memory
    import multicycle_data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16384,
    parameter int LATENCY    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_is_input_valid,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_is_ready,
    output logic                  o_is_output_valid,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_req_error
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    mem_state_t            r_state;
    mem_op_t               r_op;
    logic [3:0]            r_count;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_valid;
    logic                  r_err;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Upper address bits beyond the depth are dropped: addresses wrap.
    assign w_idx = IDX_W'(i_addr >> 2);
    // The access fires on the last wait cycle; a coincident reset drops it.
    assign w_en  = (r_state == MEM_WAIT) && (r_count == 4'd0) && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= MEM_IDLE;
            r_op    <= MEM_OP_READ;
            r_count <= 4'd0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                MEM_IDLE:
                    if (i_is_input_valid) begin
                        if (i_mem_read ^ i_mem_write) begin
                            r_op    <= i_mem_write ? MEM_OP_WRITE : MEM_OP_READ;
                            r_idx   <= w_idx;
                            r_wdata <= i_din;
                            r_count <= 4'(LATENCY - 1);
                            r_state <= MEM_WAIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                MEM_WAIT:
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= MEM_RESP;
                    end
                MEM_RESP: r_state <= MEM_IDLE;
                default:  r_state <= MEM_IDLE;
            endcase
        end
    end

    mem_word_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .i_clk  (i_clk),
        .i_en   (w_en),
        .i_we   (r_op == MEM_OP_WRITE),
        .i_index(r_idx),
        .i_wdata(r_wdata),
        .o_rdata(w_rdata)
    );

    assign o_is_ready        = (r_state == MEM_IDLE);
    assign o_is_output_valid = r_valid;
    assign o_dout            = (r_valid && r_op == MEM_OP_READ) ? w_rdata : '0;
    assign o_req_error       = r_err;
endmodule

// File: tb/tb_multicycle_data_memory.sv
// tb_multicycle_data_memory: table-driven and scoreboarded check of the multicycle data memory.
module tb_multicycle_data_memory;
    localparam int LATENCY   = 4;
    localparam int MEM_DEPTH = 16384;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        mr = 1'b0;
    logic        mw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic        ready;
    logic        ovld;
    logic [31:0] dout;
    logic        err;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    sb_t  q[$];
    vec_t tbl[11];

    multicycle_data_memory #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (MEM_DEPTH),
        .LATENCY   (LATENCY)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_is_input_valid (vld),
        .i_mem_read       (mr),
        .i_mem_write      (mw),
        .i_addr           (addr),
        .i_din            (din),
        .o_is_ready       (ready),
        .o_is_output_valid(ovld),
        .o_dout           (dout),
        .o_req_error      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ovld) begin
            if (q.size() == 0) begin
                chk("unexpected_response", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = q.pop_front();
                chk("resp_dout", dout, e.exp);
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input bit push);
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) chk("ready_timeout", {31'd0, ready}, 32'd1);
        vld = 1'b1; mr = rd; mw = wr; addr = a; din = d;
        @(posedge clk); #1;
        vld = 1'b0; mr = 1'b0; mw = 1'b0;
        if (push) q.push_back('{exp, cyc + LATENCY});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'h10, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b1, 32'h10, 32'h0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 32'h20, 32'h11111111, 32'h0};
        tbl[3]  = '{1'b1, 32'h20, 32'h0, 32'h11111111};
        tbl[4]  = '{1'b0, 32'h24, 32'hCAFEF00D, 32'h0};
        tbl[5]  = '{1'b0, 32'h24, 32'h0BADF00D, 32'h0};
        tbl[6]  = '{1'b1, 32'h24, 32'h0, 32'h0BADF00D};
        tbl[7]  = '{1'b0, 32'(MEM_DEPTH * 4 + 8), 32'hA5A5A5A5, 32'h0};
        tbl[8]  = '{1'b1, 32'h8, 32'h0, 32'hA5A5A5A5};
        tbl[9]  = '{1'b1, 32'h13, 32'h0, 32'hDEADBEEF};
        tbl[10] = '{1'b1, 32'h20, 32'h0, 32'h11111111};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, ready}, 32'd1);
            chk("idle_valid", {31'd0, ovld}, 32'd0);
            chk("idle_dout", dout, 32'd0);
            chk("idle_err", {31'd0, err}, 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            req(tbl[i].rd, !tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].exp, 1'b1);
        drain();

        // Illegal requests: both ops, then neither op.
        for (int k = 0; k < 2; k++) begin
            vld = 1'b1; mr = (k == 0); mw = (k == 0);
            @(posedge clk); #1;
            vld = 1'b0; mr = 1'b0; mw = 1'b0;
            @(negedge clk);
            chk("illegal_err", {31'd0, err}, 32'd1);
            chk("illegal_ready", {31'd0, ready}, 32'd1);
            @(negedge clk);
            chk("illegal_err_pulse", {31'd0, err}, 32'd0);
            @(posedge clk); #1;
        end
        req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
        drain();

        // Busy drop: a write held during the read's flight must be ignored.
        req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
        vld = 1'b1; mw = 1'b1; addr = 32'h10; din = 32'hBAD0BAD0;
        repeat (LATENCY + 1) begin
            @(negedge clk);
            chk("busy_ready", {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
        end
        vld = 1'b0; mw = 1'b0;
        drain();
        req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
        drain();

        // Reset mid-write: no ack, and the write is not committed.
        req(1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, ready}, 32'd1);
        chk("rst_mid_valid", {31'd0, ovld}, 32'd0);
        repeat (LATENCY + 3) @(posedge clk);
        #1;
        req(1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
